apb_multi_slave_mem: RTL and testbench

Parametrised APB4 completer that models up to 16 memory-backed slaves behind one `pselx` bus, each with its own address window. It supports byte strobes, runtime-programmable wait states, privileged-only windows, `pslverr` generation and protocol-violation flagging. It is the DUT-side counterpart of the APB master/slave agents and lets the AVIP environment run closed-loop without external RTL.

---
 rtl/apb_global_pkg.sv | 11 +
 rtl/apb_addr_decode.sv | 37 +++
 rtl/apb_multi_slave_mem.sv | 101 ++++++++++
 tb/tb_apb_multi_slave_mem.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_global_pkg.sv
// apb_global_pkg: shared types and constants for the APB multi-slave memory
package apb_global_pkg;
   typedef enum logic {IDLE, ACCESS} apb_mem_state_e;
   localparam int MAX_WAIT = 15;
   typedef enum logic [1:0] {
      PERR_NONE,
      PERR_ENABLE_IN_IDLE,
      PERR_BUS_CHANGED,
      PERR_SEL_DROPPED
   } apb_perr_cause_e;
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps pselx/paddr onto a slave index and word offset and flags access errors
module apb_addr_decode #(
   parameter int NO_OF_SLAVES = 2,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SLAVE_MEM_WORDS = 256,
   parameter logic [31:0] SLAVE_BASE = 32'h0000_0000,
   parameter logic [31:0] SLAVE_STRIDE = 32'h0000_1000,
   parameter logic [NO_OF_SLAVES-1:0] PRIV_ONLY_MASK = '0,
   localparam int SW = NO_OF_SLAVES > 1 ? $clog2(NO_OF_SLAVES) : 1,
   localparam int WW = SLAVE_MEM_WORDS > 1 ? $clog2(SLAVE_MEM_WORDS) : 1,
   localparam int LB = $clog2(DATA_WIDTH / 8)
) (
   input  logic [NO_OF_SLAVES-1:0]  pselx,
   input  logic [ADDRESS_WIDTH-1:0] paddr,
   input  logic [2:0]               pprot,
   output logic [SW-1:0]            slave_idx,
   output logic [WW-1:0]            word_off,
   output logic                     addr_err
);
   logic [ADDRESS_WIDTH-1:0] off;
   logic one_hot;
   logic unused_prot;
   // one-hot to binary; a multi-hot select is reported as an error, so the pick among set bits is irrelevant
   always_comb begin
      slave_idx = '0;
      for (int i = 0; i < NO_OF_SLAVES; i++) if (pselx[i]) slave_idx = SW'(i);
   end
   assign one_hot = pselx != '0 && (pselx & (pselx - NO_OF_SLAVES'(1))) == '0;
   assign off = paddr - ADDRESS_WIDTH'(SLAVE_BASE) - ADDRESS_WIDTH'(SLAVE_STRIDE) * ADDRESS_WIDTH'(slave_idx);
   assign word_off = WW'(off >> LB);
   assign addr_err = !one_hot
                  || (paddr & ADDRESS_WIDTH'(DATA_WIDTH / 8 - 1)) != '0
                  || off >= ADDRESS_WIDTH'(SLAVE_MEM_WORDS * DATA_WIDTH / 8)
                  || (PRIV_ONLY_MASK[slave_idx] && !pprot[0]);
   assign unused_prot = ^pprot[2:1];
endmodule

// File: rtl/apb_multi_slave_mem.sv
// apb_multi_slave_mem: APB4 completer modelling several memory-backed slave windows
module apb_multi_slave_mem #(
   parameter int NO_OF_SLAVES = 2,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SLAVE_MEM_WORDS = 256,
   parameter logic [31:0] SLAVE_BASE = 32'h0000_0000,
   parameter logic [31:0] SLAVE_STRIDE = 32'h0000_1000,
   parameter logic [NO_OF_SLAVES-1:0] PRIV_ONLY_MASK = '0,
   parameter int MAX_WAIT = apb_global_pkg::MAX_WAIT
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic [NO_OF_SLAVES-1:0]   pselx,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [ADDRESS_WIDTH-1:0]  paddr,
   input  logic [DATA_WIDTH-1:0]     pwdata,
   input  logic [DATA_WIDTH/8-1:0]   pstrb,
   input  logic [2:0]                pprot,
   input  logic [3:0]                wait_cfg,
   output logic                      pready,
   output logic [DATA_WIDTH-1:0]     prdata,
   output logic                      pslverr,
   output logic                      protocol_err
);
   import apb_global_pkg::*;
   localparam int SW = NO_OF_SLAVES > 1 ? $clog2(NO_OF_SLAVES) : 1;
   localparam int WW = SLAVE_MEM_WORDS > 1 ? $clog2(SLAVE_MEM_WORDS) : 1;
   localparam int BW = DATA_WIDTH / 8;
   apb_mem_state_e state;
   logic [3:0] cnt, wait_ld;
   logic [SW-1:0] dec_idx, s_idx;
   logic [WW-1:0] dec_word, s_word;
   logic dec_err, setup_err, err_q, s_write;
   logic [BW-1:0] s_strb;
   logic [DATA_WIDTH-1:0] s_wdata;
   logic [NO_OF_SLAVES-1:0] s_sel;
   logic [ADDRESS_WIDTH-1:0] s_addr;
   logic setup, bus_changed, dropped, commit;
   logic [DATA_WIDTH-1:0] mem [NO_OF_SLAVES][SLAVE_MEM_WORDS];

   apb_addr_decode #(
      .NO_OF_SLAVES(NO_OF_SLAVES), .ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .SLAVE_MEM_WORDS(SLAVE_MEM_WORDS), .SLAVE_BASE(SLAVE_BASE), .SLAVE_STRIDE(SLAVE_STRIDE),
      .PRIV_ONLY_MASK(PRIV_ONLY_MASK)
   ) u_dec (
      .pselx(pselx), .paddr(paddr), .pprot(pprot),
      .slave_idx(dec_idx), .word_off(dec_word), .addr_err(dec_err)
   );

   assign setup = state == IDLE && |pselx && !penable;
   assign setup_err = dec_err || (!pwrite && pstrb != '0);
   assign wait_ld = int'(wait_cfg) > MAX_WAIT ? 4'(MAX_WAIT) : wait_cfg;
   assign pready = state == ACCESS && cnt == '0;
   assign pslverr = pready && err_q;
   assign bus_changed = pselx != s_sel || paddr != s_addr || pwrite != s_write || pwdata != s_wdata;
   assign dropped = pselx == '0 && !pready;
   assign commit = pready && s_write && !err_q;

   // bus FSM: latch the transfer at setup, count down wait states, flag bus-rule violations
   always_ff @(posedge pclk or posedge preset)
      if (preset) begin
         state <= IDLE;
         cnt <= '0;
         s_idx <= '0;
         s_word <= '0;
         s_write <= 1'b0;
         s_strb <= '0;
         s_wdata <= '0;
         s_sel <= '0;
         s_addr <= '0;
         err_q <= 1'b0;
         prdata <= '0;
         protocol_err <= 1'b0;
      end else begin
         protocol_err <= state == IDLE ? penable && |pselx : bus_changed;
         if (state == IDLE) begin
            if (setup) begin
               state <= ACCESS;
               cnt <= wait_ld;
               s_idx <= dec_idx;
               s_word <= dec_word;
               s_write <= pwrite;
               s_strb <= pstrb;
               s_wdata <= pwdata;
               s_sel <= pselx;
               s_addr <= paddr;
               err_q <= setup_err;
               if (!pwrite) prdata <= setup_err ? '0 : mem[dec_idx][dec_word];
            end
         end else if (pready || dropped) state <= IDLE;
         else cnt <= cnt - 4'd1;
      end

   // byte-lane write commit on the completion edge; the array is intentionally left unreset
   always_ff @(posedge pclk)
      if (commit)
         for (int i = 0; i < BW; i++)
            if (s_strb[i]) mem[s_idx][s_word][i*8 +: 8] <= s_wdata[i*8 +: 8];
endmodule

// File: tb/tb_apb_multi_slave_mem.sv
// tb_apb_multi_slave_mem: randomized bench with a transaction-level reference model
module tb_apb_multi_slave_mem;
   import apb_global_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] pselx = '0;
   logic penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0;
   logic [3:0] pstrb = '0, wait_cfg = '0;
   logic [2:0] pprot = '0;
   logic [1:0] rdy, serr, perr;
   logic [31:0] rd0, rd1;

   always #5 clk = ~clk;

   apb_multi_slave_mem dut (
      .pclk(clk), .preset(rst), .pselx(pselx), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .wait_cfg(wait_cfg),
      .pready(rdy[0]), .prdata(rd0), .pslverr(serr[0]), .protocol_err(perr[0])
   );

   apb_multi_slave_mem #(.PRIV_ONLY_MASK(2'b10)) dut_p (
      .pclk(clk), .preset(rst), .pselx(pselx), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .wait_cfg(wait_cfg),
      .pready(rdy[1]), .prdata(rd1), .pslverr(serr[1]), .protocol_err(perr[1])
   );

   logic [31:0] mm [2][2][256];
   logic exp_rdy = 1'b0, exp_perr = 1'b0, perr_pend = 1'b0;
   logic [1:0] exp_serr = '0;
   logic [31:0] exp_rd [2];
   int checks = 0, passes = 0, lat_run = 0, seen_lat = 0, perr_cnt = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) if (chk_en) begin
      check("pready", rdy[0], exp_rdy);
      check("pready_priv", rdy[1], exp_rdy);
      check("pslverr", serr[0], exp_serr[0]);
      check("pslverr_priv", serr[1], exp_serr[1]);
      check("prdata", rd0, exp_rd[0]);
      check("prdata_priv", rd1, exp_rd[1]);
      check("protocol_err", perr[0], exp_perr);
      check("protocol_err_priv", perr[1], exp_perr);
      if (perr[0]) perr_cnt++;
      if (|pselx && !penable && !rst) lat_run = 1;
      else if (lat_run > 0) lat_run++;
      if (rdy[0] && lat_run > 0) begin
         seen_lat = lat_run;
         lat_run = 0;
      end
   end

   function automatic logic merr(input int inst, input logic [1:0] sel, input logic [31:0] addr,
                                 input logic [2:0] pr, input logic wr, input logic [3:0] st);
      logic [31:0] off;
      off = addr - (sel == 2'b10 ? 32'h1000 : 32'h0);
      return !$onehot(sel) || addr[1:0] != 2'b00 || off >= 32'd1024
          || (inst == 1 && sel == 2'b10 && !pr[0]) || (!wr && st != 4'h0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      exp_perr = perr_pend;
      perr_pend = 1'b0;
   endtask

   task automatic idle();
      tick();
      pselx = '0;
      penable = 1'b0;
      exp_rdy = 1'b0;
      exp_serr = '0;
   endtask

   task automatic xfer(input logic [1:0] sel, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                       input int w, input apb_perr_cause_e viol = PERR_NONE);
      logic e [2];
      logic [31:0] off;
      int s, wo;
      s = sel == 2'b10 ? 1 : 0;
      off = addr - (s == 1 ? 32'h1000 : 32'h0);
      wo = int'(off[9:2]);
      for (int i = 0; i < 2; i++) e[i] = merr(i, sel, addr, pr, wr, st);
      tick();
      pselx = sel; penable = 1'b0; pwrite = wr; paddr = addr;
      pwdata = wd; pstrb = st; pprot = pr; wait_cfg = 4'(w);
      exp_rdy = 1'b0;
      exp_serr = '0;
      for (int c = 0; c <= w; c++) begin
         tick();
         penable = 1'b1;
         paddr = addr;
         if (c == 0 && !wr) for (int i = 0; i < 2; i++) exp_rd[i] = e[i] ? 32'h0 : mm[i][s][wo];
         if (viol == PERR_BUS_CHANGED && c == 1) begin
            paddr = addr ^ 32'h4;
            perr_pend = 1'b1;
         end
         if (viol == PERR_SEL_DROPPED && c == 1) begin
            pselx = '0;
            penable = 1'b0;
            perr_pend = 1'b1;
            return;
         end
         exp_rdy = c == w;
         for (int i = 0; i < 2; i++) exp_serr[i] = c == w && e[i];
      end
      if (wr) for (int i = 0; i < 2; i++) if (!e[i])
         for (int b = 0; b < 4; b++) if (st[b]) mm[i][s][wo][b*8 +: 8] = wd[b*8 +: 8];
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [1:0] sel;
      logic [31:0] a, base;
      logic wr;
      logic [3:0] st;
      int k, pc;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      settle();
      check("reset_pready", rdy[0], 32'h0);
      check("reset_prdata", rd0, 32'h0);
      check("reset_pslverr", serr[0], 32'h0);
      check("reset_protocol_err", perr[0], 32'h0);
      tick();
      rst = 1'b0;
      for (int s = 0; s < 2; s++)
         for (int w = 0; w < 16; w++)
            xfer(s == 1 ? 2'b10 : 2'b01, 32'(s * 32'h1000 + w * 4), 1'b1, $urandom, 4'hF, 3'b001, 0);
      xfer(2'b01, 32'h20, 1'b1, 32'hCAFE0020, 4'hF, 3'b001, 0);
      xfer(2'b01, 32'h14, 1'b1, 32'h0F0F0F0F, 4'hF, 3'b001, 0);
      xfer(2'b01, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 0);
      settle();
      check("t1_write_latency", seen_lat, 2);
      xfer(2'b01, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 0);
      settle();
      check("t1_read_latency", seen_lat, 2);
      check("t1_rdata", rd0, 32'hDEADBEEF);
      check("t1_pslverr", serr[0], 32'h0);
      xfer(2'b10, 32'h1004, 1'b1, 32'h11223344, 4'hF, 3'b001, 0);
      xfer(2'b10, 32'h1004, 1'b1, 32'hAABBCCDD, 4'b0101, 3'b001, 0);
      xfer(2'b10, 32'h1004, 1'b0, 32'h0, 4'h0, 3'b001, 0);
      settle();
      check("t2_merge", rd0, 32'h11BB33DD);
      check("t2_merge_priv", rd1, 32'h11BB33DD);
      xfer(2'b01, 32'h18, 1'b1, 32'h00000018, 4'hF, 3'b001, 3);
      settle();
      check("t3_latency_w3", seen_lat, 5);
      idle();
      xfer(2'b01, 32'h18, 1'b0, 32'h0, 4'h0, 3'b001, 15);
      settle();
      check("t3_latency_w15", seen_lat, 17);
      check("t3_rdata", rd0, 32'h00000018);
      xfer(2'b01, 32'h400, 1'b1, 32'h55555555, 4'hF, 3'b001, 1);
      settle();
      check("t4_gap_err", serr[0], 32'h1);
      xfer(2'b01, 32'h2, 1'b1, 32'h66666666, 4'hF, 3'b001, 0);
      settle();
      check("t4_misaligned_err", serr[0], 32'h1);
      xfer(2'b11, 32'h10, 1'b1, 32'h77777777, 4'hF, 3'b001, 2);
      settle();
      check("t4_multihot_err", serr[0], 32'h1);
      xfer(2'b01, 32'h10, 1'b0, 32'h0, 4'h1, 3'b001, 0);
      settle();
      check("t4_read_strb_err", serr[0], 32'h1);
      check("t4_read_strb_rdata", rd0, 32'h0);
      xfer(2'b01, 32'h10, 1'b0, 32'h0, 4'h0, 3'b001, 0);
      settle();
      check("t4_mem_unchanged", rd0, 32'hDEADBEEF);
      xfer(2'b10, 32'h1004, 1'b0, 32'h0, 4'h0, 3'b000, 0);
      settle();
      check("t4_priv_err", serr[1], 32'h1);
      check("t4_priv_rdata", rd1, 32'h0);
      check("t4_nonpriv_ok", serr[0], 32'h0);
      xfer(2'b01, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 0);
      settle();
      check("t4_priv_slave0_ok", serr[1], 32'h0);
      check("t4_priv_slave0_rdata", rd1, 32'hDEADBEEF);
      pc = perr_cnt;
      xfer(2'b01, 32'h1C, 1'b1, 32'h12345678, 4'hF, 3'b001, 2, PERR_BUS_CHANGED);
      idle();
      settle();
      check("t5_change_pulses", perr_cnt - pc, 1);
      pc = perr_cnt;
      xfer(2'b01, 32'h14, 1'b1, 32'hBAD0BAD0, 4'hF, 3'b001, 4, PERR_SEL_DROPPED);
      idle();
      settle();
      check("t5_drop_pulses", perr_cnt - pc, 1);
      xfer(2'b01, 32'h14, 1'b0, 32'h0, 4'h0, 3'b001, 0);
      settle();
      check("t5_drop_no_write", rd0, 32'h0F0F0F0F);
      tick();
      pselx = 2'b01;
      penable = 1'b1;
      exp_rdy = 1'b0;
      exp_serr = '0;
      perr_pend = 1'b1;
      idle();
      tick();
      pselx = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20;
      pwdata = 32'h99999999; pstrb = 4'hF; pprot = 3'b001; wait_cfg = 4'd5;
      tick();
      penable = 1'b1;
      tick();
      rst = 1'b1;
      pselx = '0;
      penable = 1'b0;
      exp_rdy = 1'b0; exp_serr = '0; exp_perr = 1'b0; perr_pend = 1'b0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      settle();
      check("t6_reset_pready", rdy[0], 32'h0);
      check("t6_reset_prdata", rd0, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      xfer(2'b01, 32'h20, 1'b0, 32'h0, 4'h0, 3'b001, 1);
      settle();
      check("t6_old_data", rd0, 32'hCAFE0020);
      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 99);
         sel = k < 4 ? 2'b11 : ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b01);
         base = sel == 2'b10 ? 32'h1000 : 32'h0;
         a = base + 4 * $urandom_range(0, 15);
         k = $urandom_range(0, 19);
         if (k == 0) a = base + 32'h400 + 4 * $urandom_range(0, 15);
         else if (k == 1) a = a | $urandom_range(1, 3);
         wr = $urandom_range(0, 1) == 1;
         st = wr ? 4'($urandom) : ($urandom_range(0, 9) == 0 ? 4'($urandom_range(1, 15)) : 4'h0);
         xfer(sel, a, wr, $urandom, st, 3'($urandom), $urandom_range(0, 4));
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      settle();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
